// File: rtl/rom_bus_if.sv
// Processor-side instruction bus as seen by a ROM responder: phase sync, ROM command,
// the resolved data-bus nibble, and this chip's drive onto the bus.
interface rom_bus_if;
  logic       sync;
  logic       cm_rom;
  logic [3:0] data_in;
  logic [3:0] data_out;
  logic       data_oe;

  modport master (output sync, cm_rom, data_in, input  data_out, data_oe);
  modport slave  (input  sync, cm_rom, data_in, output data_out, data_oe);
endinterface

// File: rtl/rom_bus_responder.sv
// Program-ROM end of the 8-state instruction bus cycle: tracks A1..X3 from sync,
// serves the addressed byte in M1/M2, and runs the SRC/WRR/RDR-controlled I/O port.
module rom_bus_responder #(
  parameter logic [3:0] CHIP_ID = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  rom_bus_if.slave   bus,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic [3:0] io_in,
  output logic [3:0] io_out,
  output logic [2:0] cycle_state,
  output logic       locked
);

  localparam logic [2:0] ST_A1 = 3'd0;
  localparam logic [2:0] ST_A2 = 3'd1;
  localparam logic [2:0] ST_A3 = 3'd2;
  localparam logic [2:0] ST_M1 = 3'd3;
  localparam logic [2:0] ST_M2 = 3'd4;
  localparam logic [2:0] ST_X2 = 3'd6;
  localparam logic [2:0] ST_X3 = 3'd7;

  logic [2:0] state_q, state_d;
  logic       locked_q, locked_d;
  logic [3:0] addr_lo_q, addr_lo_d;
  logic [7:0] rom_addr_q, rom_addr_d;
  logic       sel_q, sel_d;
  logic [7:0] fetch_byte_q, fetch_byte_d;
  logic [3:0] opr_q, opr_d;
  logic       operand_next_q, operand_next_d;
  logic       operand_cycle_q, operand_cycle_d;
  logic       src_pend_q, src_pend_d;
  logic       wrr_pend_q, wrr_pend_d;
  logic       rdr_pend_q, rdr_pend_d;
  logic       io_sel_q, io_sel_d;
  logic [3:0] io_out_q, io_out_d;

  logic [7:0] opcode;
  logic       two_byte, is_src, mid_sync;

  // opa is the nibble on the bus during M2, so the decode uses it directly.
  assign opcode   = {opr_q, bus.data_in};
  assign two_byte = (opr_q == 4'h1) || (opr_q == 4'h2 && !bus.data_in[0]) ||
                    (opr_q == 4'h4) || (opr_q == 4'h5) || (opr_q == 4'h7);
  assign is_src   = (opr_q == 4'h2) && bus.data_in[0];
  assign mid_sync = bus.sync && (state_q != ST_X3);

  always_comb begin
    state_d         = bus.sync ? ST_A1 : state_q + 3'd1;
    locked_d        = locked_q | bus.sync;
    addr_lo_d       = addr_lo_q;
    rom_addr_d      = rom_addr_q;
    sel_d           = sel_q;
    fetch_byte_d    = fetch_byte_q;
    opr_d           = opr_q;
    operand_next_d  = operand_next_q;
    operand_cycle_d = operand_cycle_q;
    src_pend_d      = src_pend_q;
    wrr_pend_d      = wrr_pend_q;
    rdr_pend_d      = rdr_pend_q;
    io_sel_d        = io_sel_q;
    io_out_d        = io_out_q;

    if (locked_q) begin
      case (state_q)
        ST_A1: begin
          addr_lo_d       = bus.data_in;
          operand_cycle_d = operand_next_q;
        end
        ST_A2: rom_addr_d = {bus.data_in, addr_lo_q};
        ST_A3: begin
          sel_d        = bus.cm_rom && (bus.data_in == CHIP_ID);
          fetch_byte_d = rom_data;
        end
        ST_M1: opr_d = bus.data_in;
        ST_M2: begin
          if (operand_cycle_q) begin
            operand_next_d = 1'b0;
            src_pend_d     = 1'b0;
            wrr_pend_d     = 1'b0;
            rdr_pend_d     = 1'b0;
          end else begin
            operand_next_d = two_byte;
            src_pend_d     = is_src;
            wrr_pend_d     = (opcode == 8'hE2) && io_sel_q;
            rdr_pend_d     = (opcode == 8'hEA) && io_sel_q;
          end
        end
        ST_X2: begin
          if (src_pend_q && bus.cm_rom) io_sel_d = (bus.data_in == CHIP_ID);
          if (wrr_pend_q) io_out_d = bus.data_in;
        end
        ST_X3: begin
          src_pend_d = 1'b0;
          wrr_pend_d = 1'b0;
          rdr_pend_d = 1'b0;
        end
        default: ;
      endcase
    end

    // A resync mid-cycle throws away the half-built instruction but keeps port state.
    if (mid_sync) begin
      sel_d          = 1'b0;
      operand_next_d = 1'b0;
      src_pend_d     = 1'b0;
      wrr_pend_d     = 1'b0;
      rdr_pend_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_X3;
      locked_q        <= 1'b0;
      addr_lo_q       <= 4'h0;
      rom_addr_q      <= 8'h00;
      sel_q           <= 1'b0;
      fetch_byte_q    <= 8'h00;
      opr_q           <= 4'h0;
      operand_next_q  <= 1'b0;
      operand_cycle_q <= 1'b0;
      src_pend_q      <= 1'b0;
      wrr_pend_q      <= 1'b0;
      rdr_pend_q      <= 1'b0;
      io_sel_q        <= 1'b0;
      io_out_q        <= 4'h0;
    end else begin
      state_q         <= state_d;
      locked_q        <= locked_d;
      addr_lo_q       <= addr_lo_d;
      rom_addr_q      <= rom_addr_d;
      sel_q           <= sel_d;
      fetch_byte_q    <= fetch_byte_d;
      opr_q           <= opr_d;
      operand_next_q  <= operand_next_d;
      operand_cycle_q <= operand_cycle_d;
      src_pend_q      <= src_pend_d;
      wrr_pend_q      <= wrr_pend_d;
      rdr_pend_q      <= rdr_pend_d;
      io_sel_q        <= io_sel_d;
      io_out_q        <= io_out_d;
    end
  end

  // Drive enable depends only on registered state; RDR passes io_in straight through.
  always_comb begin
    bus.data_oe  = 1'b0;
    bus.data_out = 4'h0;
    if (locked_q) begin
      case (state_q)
        ST_M1: if (sel_q) begin
          bus.data_oe  = 1'b1;
          bus.data_out = fetch_byte_q[7:4];
        end
        ST_M2: if (sel_q) begin
          bus.data_oe  = 1'b1;
          bus.data_out = fetch_byte_q[3:0];
        end
        ST_X2: if (rdr_pend_q) begin
          bus.data_oe  = 1'b1;
          bus.data_out = io_in;
        end
        default: ;
      endcase
    end
  end

  assign rom_addr    = rom_addr_q;
  assign io_out      = io_out_q;
  assign cycle_state = state_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_rom_bus_responder.sv
// Directed bench for rom_bus_responder: plays the processor side of whole bus cycles
// and checks drive windows, fetched nibbles and I/O port behaviour against hand values.
module tb_rom_bus_responder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [3:0] io_in = 4'h0;
  logic [3:0] io_out;
  logic [2:0] cycle_state;
  logic       locked;

  rom_bus_if bus();

  rom_bus_responder #(.CHIP_ID(4'h3)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .io_in      (io_in),
    .io_out     (io_out),
    .cycle_state(cycle_state),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  // Program array: one known byte at 0xA5, everything else a distinct filler.
  assign rom_data = (rom_addr == 8'hA5) ? 8'hC7 : ~rom_addr;

  int total = 0;
  int bad   = 0;

  logic [2:0] obs_st [8];
  logic [3:0] obs_do [8];
  logic [3:0] obs_io [8];
  logic [7:0] oe_mask;

  task automatic step(input logic [3:0] din, input logic cm, input logic sy);
    @(posedge clk);
    #1;
    bus.data_in = din;
    bus.cm_rom  = cm;
    bus.sync    = sy;
    @(negedge clk);
  endtask

  // One full A1..X3 cycle starting in A1, with sync during X3.
  task automatic bus_cycle(input logic [3:0] a1, a2, a3, input logic cm3,
                           input logic [3:0] opr, opa, x2, input logic cm6);
    logic [3:0] din;
    oe_mask = 8'h00;
    for (int s = 0; s < 8; s++) begin
      case (s)
        0: din = a1;
        1: din = a2;
        2: din = a3;
        3: din = opr;
        4: din = opa;
        6: din = x2;
        default: din = 4'h0;
      endcase
      step(din, (s == 2) ? cm3 : (s == 6) ? cm6 : 1'b0, s == 7);
      obs_st[s]  = cycle_state;
      obs_do[s]  = bus.data_out;
      obs_io[s]  = io_out;
      oe_mask[s] = bus.data_oe;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (cycle_state !== 3'd7) begin bad++; $display("FAIL reset_state got=%0d exp=7", cycle_state); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
    total++; if (bus.data_oe !== 1'b0 || bus.data_out !== 4'h0) begin bad++; $display("FAIL reset_drive got oe=%b do=%h exp oe=0 do=0", bus.data_oe, bus.data_out); end
    total++; if (rom_addr !== 8'h00) begin bad++; $display("FAIL reset_rom_addr got=%h exp=00", rom_addr); end
    total++; if (io_out !== 4'h0) begin bad++; $display("FAIL reset_io_out got=%h exp=0", io_out); end
  endtask

  task automatic test_lock_and_phase;
    logic any_oe = 1'b0;
    // Pre-lock: bus looks like a selecting fetch, but nothing may be driven.
    for (int i = 0; i < 5; i++) begin
      step(4'h3, 1'b1, 1'b0);
      any_oe |= bus.data_oe;
    end
    total++; if (any_oe !== 1'b0 || locked !== 1'b0) begin bad++; $display("FAIL prelock got oe_seen=%b locked=%b exp 0 0", any_oe, locked); end
    step(4'h0, 1'b0, 1'b1);
    for (int s = 0; s < 8; s++) begin
      step(4'h0, 1'b0, s == 7);
      total++; if (cycle_state !== 3'(s) || locked !== 1'b1) begin bad++; $display("FAIL phase_step got state=%0d locked=%b exp state=%0d locked=1", cycle_state, locked, s); end
    end
    // Resync injected while in M1.
    repeat (3) step(4'h0, 1'b0, 1'b0);
    step(4'h0, 1'b0, 1'b1);
    total++; if (cycle_state !== 3'd3) begin bad++; $display("FAIL resync_at got=%0d exp=3", cycle_state); end
    step(4'h0, 1'b0, 1'b0);
    total++; if (cycle_state !== 3'd0) begin bad++; $display("FAIL resync_next got=%0d exp=0", cycle_state); end
    repeat (6) step(4'h0, 1'b0, 1'b0);
    step(4'h0, 1'b0, 1'b1);
  endtask

  task automatic test_fetch;
    bus_cycle(4'h5, 4'hA, 4'h3, 1'b1, 4'hC, 4'h7, 4'h0, 1'b0);
    total++; if (oe_mask !== 8'b0001_1000) begin bad++; $display("FAIL fetch_oe_mask got=%b exp=00011000", oe_mask); end
    total++; if (obs_do[3] !== 4'hC) begin bad++; $display("FAIL fetch_m1 got=%h exp=c", obs_do[3]); end
    total++; if (obs_do[4] !== 4'h7) begin bad++; $display("FAIL fetch_m2 got=%h exp=7", obs_do[4]); end
    total++; if (rom_addr !== 8'hA5) begin bad++; $display("FAIL fetch_rom_addr got=%h exp=a5", rom_addr); end
    total++; if (obs_st[3] !== 3'd3 || obs_st[4] !== 3'd4) begin bad++; $display("FAIL fetch_states got=%0d,%0d exp=3,4", obs_st[3], obs_st[4]); end
    // Wrong chip number, then right chip without the ROM command.
    bus_cycle(4'h5, 4'hA, 4'h2, 1'b1, 4'hC, 4'h7, 4'h0, 1'b0);
    total++; if (oe_mask !== 8'h00) begin bad++; $display("FAIL deselect_chip got=%b exp=00000000", oe_mask); end
    bus_cycle(4'h5, 4'hA, 4'h3, 1'b0, 4'hC, 4'h7, 4'h0, 1'b0);
    total++; if (oe_mask !== 8'h00) begin bad++; $display("FAIL deselect_cm got=%b exp=00000000", oe_mask); end
  endtask

  task automatic test_src_wrr;
    bus_cycle(4'h0, 4'h0, 4'h0, 1'b0, 4'h2, 4'h1, 4'h3, 1'b1);
    bus_cycle(4'h0, 4'h0, 4'h0, 1'b0, 4'hE, 4'h2, 4'h9, 1'b0);
    total++; if (obs_io[6] !== 4'h0) begin bad++; $display("FAIL wrr_before_edge got=%h exp=0", obs_io[6]); end
    total++; if (obs_io[7] !== 4'h9) begin bad++; $display("FAIL wrr_after_x2 got=%h exp=9", obs_io[7]); end
    total++; if (oe_mask !== 8'h00) begin bad++; $display("FAIL wrr_no_drive got=%b exp=00000000", oe_mask); end
    bus_cycle(4'h0, 4'h0, 4'h0, 1'b0, 4'h2, 4'h1, 4'h4, 1'b1);
    bus_cycle(4'h0, 4'h0, 4'h0, 1'b0, 4'hE, 4'h2, 4'h5, 1'b0);
    total++; if (io_out !== 4'h9) begin bad++; $display("FAIL wrr_other_chip got=%h exp=9", io_out); end
  endtask

  task automatic test_rdr;
    io_in = 4'h6;
    bus_cycle(4'h0, 4'h0, 4'h0, 1'b0, 4'hE, 4'hA, 4'h0, 1'b0);
    total++; if (oe_mask !== 8'h00) begin bad++; $display("FAIL rdr_unselected got=%b exp=00000000", oe_mask); end
    bus_cycle(4'h0, 4'h0, 4'h0, 1'b0, 4'h2, 4'h1, 4'h3, 1'b1);
    bus_cycle(4'h0, 4'h0, 4'h0, 1'b0, 4'hE, 4'hA, 4'h6, 1'b0);
    total++; if (oe_mask !== 8'b0100_0000) begin bad++; $display("FAIL rdr_oe_mask got=%b exp=01000000", oe_mask); end
    total++; if (obs_do[6] !== 4'h6) begin bad++; $display("FAIL rdr_data got=%h exp=6", obs_do[6]); end
  endtask

  task automatic test_two_byte;
    // io_sel is set: an operand 0x21 with chip 4 in X2 must not deselect the port.
    bus_cycle(4'h0, 4'h0, 4'h0, 1'b0, 4'h4, 4'h0, 4'h0, 1'b0);
    bus_cycle(4'h0, 4'h0, 4'h0, 1'b0, 4'h2, 4'h1, 4'h4, 1'b1);
    bus_cycle(4'h0, 4'h0, 4'h0, 1'b0, 4'hE, 4'h2, 4'hB, 1'b0);
    total++; if (io_out !== 4'hB) begin bad++; $display("FAIL jun_operand_guard got=%h exp=b", io_out); end
    bus_cycle(4'h0, 4'h0, 4'h0, 1'b0, 4'h2, 4'h0, 4'h0, 1'b0);
    bus_cycle(4'h0, 4'h0, 4'h0, 1'b0, 4'hE, 4'hA, 4'h0, 1'b0);
    total++; if (oe_mask !== 8'h00) begin bad++; $display("FAIL fim_operand_guard got=%b exp=00000000", oe_mask); end
  endtask

  task automatic test_reset_mid_cycle;
    step(4'h5, 1'b0, 1'b0);
    step(4'hA, 1'b0, 1'b0);
    step(4'h3, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    bus.data_in = 4'hC;
    bus.cm_rom  = 1'b0;
    rst         = 1'b1;
    @(negedge clk);
    total++; if (bus.data_oe !== 1'b1 || bus.data_out !== 4'hC) begin bad++; $display("FAIL rst_m1_drive got oe=%b do=%h exp oe=1 do=c", bus.data_oe, bus.data_out); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (bus.data_oe !== 1'b0 || cycle_state !== 3'd7 || locked !== 1'b0) begin bad++; $display("FAIL rst_mid_cycle got oe=%b state=%0d locked=%b exp 0 7 0", bus.data_oe, cycle_state, locked); end
    total++; if (io_out !== 4'h0) begin bad++; $display("FAIL rst_io_out got=%h exp=0", io_out); end
  endtask

  initial begin
    bus.sync    = 1'b0;
    bus.cm_rom  = 1'b0;
    bus.data_in = 4'h0;
    test_reset();
    test_lock_and_phase();
    test_fetch();
    test_src_wrr();
    test_rdr();
    test_two_byte();
    test_reset_mid_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_bus_responder.md
# rom_bus_responder

Memory-side end of the 8-state instruction bus cycle: a 4001-style program-ROM responder for the Miyamii-4000. It tracks the processor's A1..X3 cycle from `sync`, assembles the 8-bit address from bus nibbles, and returns the addressed instruction byte as two nibbles in M1/M2. It decodes SRC/WRR/RDR from the bus so its 4-bit I/O port can be written and read. One instance per ROM chip, selected by `CHIP_ID`.

## Interface
- `CHIP_ID`, 4'h0: chip number matched in A3 (fetch) and X2 (SRC).
- `clk` input 1: single system clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `sync` input 1: high for the X3 cycle; the next cycle is A1.
- `cm_rom` input 1: ROM command line, sampled in A3 and X2.
- `data_in` input 4: resolved data-bus value, including this chip's own drive.
- `data_out` output 4: nibble driven onto the bus.
- `data_oe` output 1: bus drive enable.
- `rom_addr` output 8: registered byte address to the program array.
- `rom_data` input 8: array byte, valid one cycle after `rom_addr` changes.
- `io_in` input 4: I/O port input pins.
- `io_out` output 4: I/O port output latch.
- `cycle_state` output 3: tracked state, A1=0 … X3=7.
- `locked` output 1: a `sync` has been seen since reset.

## Operation
- Phase counter:
  - On `sync`=1, the next state is A1.
  - Otherwise the counter increments and wraps 7→0.
  - A `sync` in any state resynchronises; it is not an error.
  - `locked` sets on the first `sync` and stays set until `rst`.
  - While `locked`=0 there are no captures and no drive.
- A1: capture `data_in` as addr[3:0].
- A2: `rom_addr` ← {`data_in`, addr[3:0]}, registered at the end of A2.
- A3:
  - `sel` ← `cm_rom` && (`data_in` == `CHIP_ID`).
  - `fetch_byte` ← `rom_data`.
- M1: `opr` ← `data_in`. If `sel`, `data_out` = `fetch_byte[7:4]` and `data_oe` = 1.
- M2: `opa` ← `data_in`. If `sel`, `data_out` = `fetch_byte[3:0]` and `data_oe` = 1.
- End of M2, decode {`opr`,`opa`} only when `operand_cycle`=0:
  - Two-byte opcodes set `operand_next`: JCN 0001xxxx, FIM 0010xxx0, JUN 0100xxxx, JMS 0101xxxx, ISZ 0111xxxx.
  - SRC 0010xxx1 sets `src_pend`.
  - WRR 0xE2 sets `wrr_pend`, provided `io_sel` is already set.
  - RDR 0xEA sets `rdr_pend`, provided `io_sel` is already set.
  - Any other opcode clears all pend flags.
- `operand_cycle` ← `operand_next` at the A1 of the next cycle. An operand byte is never decoded and clears the pend flags.
- X2:
  - `src_pend` && `cm_rom`: `io_sel` ← (`data_in` == `CHIP_ID`).
  - `wrr_pend`: `io_out` ← `data_in`.
  - `rdr_pend`: `data_out` = `io_in` and `data_oe` = 1.
- X1, X3: no drive, no capture. All pend flags clear at the end of X3.
- `data_oe`:
  - Combinational from registered state only.
  - Never asserted outside M1, M2 or X2.
  - When `data_oe`=0, `data_out` = 0.

## Timing
- Fetch latency: the byte addressed in A1/A2 is on the bus in M1 (high nibble) and M2 (low nibble) of the same cycle, 2 and 3 clocks after the A2 capture.
- `rom_data` is sampled exactly once per cycle, at the end of A3.
- Port latency: `io_out` updates on the edge ending X2 of the WRR cycle. RDR drives during X2 with no latency from `io_in`.
- `io_sel` persists across cycles until the next SRC.
- Reset values:
  - `cycle_state`=7, `locked`=0, `rom_addr`=0.
  - `io_out`=0, `data_out`=0, `data_oe`=0.
  - Internal: `sel`=0, `io_sel`=0, pend flags=0, `operand_cycle`=0, `operand_next`=0.
- Reset mid-cycle:
  - Next state is 7 and `locked`=0.
  - Drive drops on the cycle after `rst` is sampled.
- `sync` landing mid-cycle: partial captures are discarded and pend flags clear; `io_sel` and `io_out` are kept.
- Simultaneous SRC match and a WRR in the same cycle cannot occur, since the flags are one-hot by decode.

## Test plan
- Reset then `sync`: `data_oe`=0 throughout the pre-lock cycles. After `sync`, `cycle_state` steps 0..7. A second `sync` injected at state 3 forces state 0 next.
- Fetch select: `CHIP_ID`=3, A1=0x5, A2=0xA, `rom_data`=0xC7 when `rom_addr`=0xA5, A3 `data_in`=3 with `cm_rom`=1 → M1 drives 0xC, M2 drives 0x7.
- Fetch deselect: same sequence with A3 `data_in`=2 → `data_oe`=0 in all states.
- SRC then WRR: SRC 0x21 with X2 `data_in`=3 and `cm_rom`=1; next cycle WRR 0xE2 with X2 `data_in`=0x9 → `io_out`=0x9. Repeat with SRC chip 4 → `io_out` unchanged.
- RDR: after a matching SRC, `io_in`=0x6 and opcode 0xEA → X2 `data_oe`=1, `data_out`=0x6.
- Two-byte guard: JUN 0x40, then operand byte 0x21, then WRR → no SRC is taken and `io_sel` is unchanged. Apply `rst` during M1 → `data_oe`=0 and `cycle_state`=7 on the next cycle.
